dmem_responder: RTL

//  Memory-side responder for the CPU data-memory port: request/response handshake with

---
 rtl/dmem_if.sv | 23 ++
 rtl/dmem_responder.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/dmem_if.sv
// Request/response bundle between the CPU data-memory initiator and the memory responder.
interface dmem_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_wen, req_addr, req_wdata, req_be, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_wen, req_addr, req_wdata, req_be, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding request, fixed LATENCY, byte-enabled writes, range check.
// Optional macro DMEM_MISALIGN_TRAP_EN: fault any access whose addr[1:0] is non-zero.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned LATENCY     = 2
) (
  input  logic  clk,
  input  logic  reset,
  dmem_if.slave bus
);

  localparam int unsigned IDX_W  = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN   = 32'(DEPTH_WORDS * 4);
  localparam logic [3:0]  LAT_M1 = 4'(LATENCY - 1);
`ifdef DMEM_MISALIGN_TRAP_EN
  localparam logic TRAP_EN = 1'b1;
`else
  localparam logic TRAP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e             state_r, state_s;
  logic [3:0]         cnt_r, cnt_s;
  logic               wen_r;
  logic [3:0]         be_r;
  logic [31:0]        wdata_r;
  logic [IDX_W-1:0]   idx_r;
  logic               err_r;
  logic               req_ready_r;
  logic               resp_valid_r;
  logic [31:0]        resp_rdata_r;
  logic               resp_err_r;
  logic [31:0]        mem_r [DEPTH_WORDS];

  logic [31:0]        offset_s;
  logic [IDX_W-1:0]   idx_s;
  logic               fault_s;
  logic               accept_s;
  logic               commit_s;
  logic               txn_wen_s;
  logic [3:0]         txn_be_s;
  logic [31:0]        txn_wdata_s;
  logic [IDX_W-1:0]   txn_idx_s;
  logic               txn_err_s;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  be);
    logic [31:0] merged;
    merged = old_word;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) begin
        merged[8*i +: 8] = new_word[8*i +: 8];
      end else begin
        merged[8*i +: 8] = old_word[8*i +: 8];
      end
    end
    return merged;
  endfunction

  // Address decode of the incoming request; unsigned subtraction folds "below base" into out-of-range.
  always_comb begin
    offset_s = bus.req_addr - BASE_ADDR;
    idx_s    = offset_s[IDX_W+1:2];
    fault_s  = (offset_s >= SPAN) || (TRAP_EN && (bus.req_addr[1:0] != 2'b00));
  end

  // With LATENCY=1 the commit edge is the accept edge, so the live request is used in IDLE.
  always_comb begin
    accept_s = (state_r == ST_IDLE) && bus.req_valid;
    if (state_r == ST_IDLE) begin
      txn_wen_s   = bus.req_wen;
      txn_be_s    = bus.req_be;
      txn_wdata_s = bus.req_wdata;
      txn_idx_s   = idx_s;
      txn_err_s   = fault_s;
    end else begin
      txn_wen_s   = wen_r;
      txn_be_s    = be_r;
      txn_wdata_s = wdata_r;
      txn_idx_s   = idx_r;
      txn_err_s   = err_r;
    end
  end

  // Next-state and latency-counter logic.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.req_valid) begin
          cnt_s   = LAT_M1;
          state_s = (LATENCY > 1) ? ST_WAIT : ST_RESP;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        cnt_s = cnt_r - 4'd1;
        if (cnt_r <= 4'd1) begin
          state_s = ST_RESP;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_RESP: begin
        if (bus.resp_ready) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_RESP;
        end
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = 4'd0;
      end
    endcase
    commit_s = (state_s == ST_RESP) && (state_r != ST_RESP);
  end

  // Control state, latched request and registered response outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= ST_IDLE;
      cnt_r        <= 4'd0;
      wen_r        <= 1'b0;
      be_r         <= 4'd0;
      wdata_r      <= 32'd0;
      idx_r        <= '0;
      err_r        <= 1'b0;
      req_ready_r  <= 1'b1;
      resp_valid_r <= 1'b0;
      resp_rdata_r <= 32'd0;
      resp_err_r   <= 1'b0;
    end else begin
      state_r      <= state_s;
      cnt_r        <= cnt_s;
      req_ready_r  <= (state_s == ST_IDLE);
      resp_valid_r <= (state_s == ST_RESP);
      if (accept_s) begin
        wen_r   <= bus.req_wen;
        be_r    <= bus.req_be;
        wdata_r <= bus.req_wdata;
        idx_r   <= idx_s;
        err_r   <= fault_s;
      end else begin
        wen_r   <= wen_r;
        be_r    <= be_r;
        wdata_r <= wdata_r;
        idx_r   <= idx_r;
        err_r   <= err_r;
      end
      if (commit_s) begin
        resp_rdata_r <= (txn_err_s || txn_wen_s) ? 32'd0 : mem_r[txn_idx_s];
        resp_err_r   <= txn_err_s;
      end else if ((state_r == ST_RESP) && bus.resp_ready) begin
        resp_rdata_r <= 32'd0;
        resp_err_r   <= 1'b0;
      end else begin
        resp_rdata_r <= resp_rdata_r;
        resp_err_r   <= resp_err_r;
      end
    end
  end

  // Storage is never cleared; the reset gate stops a LATENCY=1 commit while reset is held.
  always_ff @(posedge clk) begin
    if (reset && commit_s && txn_wen_s && !txn_err_s) begin
      mem_r[txn_idx_s] <= merge_bytes(mem_r[txn_idx_s], txn_wdata_s, txn_be_s);
    end
  end

  assign bus.req_ready  = req_ready_r;
  assign bus.resp_valid = resp_valid_r;
  assign bus.resp_rdata = resp_rdata_r;
  assign bus.resp_err   = resp_err_r;

endmodule
